csa_resolve: RTL and testbench

CSA_RESOLVE -- requirements
Module: csa_resolve

---
 rtl/csa_resolve.sv | 116 +++++++++++
 tb/tb_csa_resolve.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve.sv
// Resolves a carry-save (sum, carry) pair plus carry-in into a binary N+1 bit
// result, SEG bits per clock, with valid/ready handshakes on both sides.
module csa_resolve #(
    parameter int N   = 64,
    parameter int SEG = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] sum_in,
    input  logic [N-1:0] carry_in,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result_out
);

    localparam int NSEG = N / SEG;
    localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           c_q, c_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [N:0]     result_q, result_d;
    logic [N-1:0]   sum_q, carry_q;
    logic           cap_en;
    logic [SEG:0]   seg_sum;
    int             seg_lo;

    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    endfunction

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cap_en      = 1'b0;
        seg_lo      = int'(k_q) * SEG;
        seg_sum     = seg_add(sum_q[seg_lo +: SEG], carry_q[seg_lo +: SEG], c_q);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    cap_en  = 1'b1;
                    k_d     = '0;
                    c_d     = cin;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[seg_lo +: SEG] = seg_sum[SEG-1:0];
                c_d = seg_sum[SEG];
                if (k_q == KW'(NSEG - 1)) begin
                    // Final segment: its carry-out becomes the result MSB.
                    result_d[N] = seg_sum[SEG];
                    k_d         = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready tracks the state being entered, so it drops on the
        // accepting edge and rises the cycle after the output handshake.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            c_q         <= c_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            sum_q   <= sum_in;
            carry_q <= carry_in;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Directed and randomized bench for csa_resolve (N=64, SEG=16) with an
// expected-result queue drained by an independent output monitor.
module tb_csa_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum_in;
    logic [63:0] carry_in;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [64:0] result_out;

    logic [64:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          npush  = 0;
    int          nres   = 0;
    bit          rand_or = 1'b0;

    csa_resolve #(.N(64), .SEG(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_in     (sum_in),
        .carry_in   (carry_in),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: one pop per output handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            nres++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h expected=none", result_out);
            end else begin
                check("result", result_out, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic ci, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
        in_valid = 1'b1;
        sum_in   = s;
        carry_in = c;
        cin      = ci;
        tick();
        in_valid = 1'b0;
        sum_in   = $urandom;
        carry_in = $urandom;
        cin      = 1'($urandom_range(0, 1));
        if (push) begin
            sb.push_back({1'b0, s} + {1'b0, c} + {64'd0, ci});
            npush++;
        end
    endtask

    task automatic run_one(input logic [63:0] s, input logic [63:0] c, input logic ci);
        int n = 0;
        send(s, c, ci, 1'b1);
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        if (!in_ready) check("complete_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [64:0] held;
        logic [63:0] a, b;
        int          lat;
        bit          seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        carry_in  = '0;
        cin       = 1'b0;

        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result_out, 65'd0);
        reset = 1'b0;
        check("in_ready_before_edge", in_ready, 1'b0);
        tick();
        check("in_ready_after_release", in_ready, 1'b1);

        // All-ones plus cin ripples across every segment; latency and hold.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 65'(lat), 65'd4);
        check("ones_cin_value", result_out, 65'h1_0000_0000_0000_0000);
        held = result_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", result_out, held);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);

        out_ready = 1'b1;
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_one(64'h0000_0000_0001_8000, 64'h0000_0000_0000_8000, 1'b0);
        run_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        run_one(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);

        // Async reset two edges into RUN discards the operation.
        out_ready = 1'b0;
        send(64'h0000_0000_0000_1234, 64'd1, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_in_ready", in_ready, 1'b0);
        check("async_result", result_out, 65'd0);
        tick();
        reset = 1'b0;
        tick();
        check("in_ready_after_async", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("no_pulse_after_abort", seen, 1'b0);
        out_ready = 1'b1;
        run_one(64'd5, 64'd7, 1'b0);

        // Randomized back-to-back traffic with random output back-pressure.
        rand_or = 1'b1;
        for (int i = 0; i < 24; i++) begin
            int gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) tick();
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 6 == 5) a = '1;
            send(a, b, 1'($urandom_range(0, 1)), 1'b1);
        end
        rand_or   = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 300 && (sb.size() != 0 || out_valid); n++) tick();
        tick();
        check("queue_drained", 65'(sb.size()), 65'd0);
        check("result_count", 65'(nres), 65'(npush));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
